// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of the FIFO write port among NREQ requesters.
// Optional macro ARB_PRI0_EN: requester 0 takes every other grant slot while it requests.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    input  logic                 full,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      gnt,
    output logic                 wr_en,
    output logic [DW-1:0]        d_in,
    output logic                 busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BURST - 1);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   last_owner_q;
    logic [CW-1:0]   beat_cnt_q;
    logic [NREQ-1:0] gnt_q;

    logic [DW-1:0]   data_arr [NREQ];
    logic            owner_req;
    logic            owner_last;
    logic            accept;
    logic            exit_burst;
    logic [IW-1:0]   pick_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign data_arr[gi] = req_data[gi*DW +: DW];
            assign ack[gi]      = accept && (owner_q == IW'(gi));
        end
    endgenerate

    // First set bit of mask strictly after ptr, wrapping modulo NREQ.
    function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] ptr,
                                              input logic [NREQ-1:0] mask);
        logic [IW-1:0]   pick;
        logic            found;
        logic [NREQ-1:0] rot;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            rot = mask >> idx;
            if (!found && rot[0]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef ARB_PRI0_EN
    // Separate pointer over requesters 1..NREQ-1 so the others still rotate
    // fairly between the slots requester 0 takes.
    logic [IW-1:0]   rr_ptr_q;
    logic [NREQ-1:0] rest_req;

    always_comb begin
        rest_req    = req;
        rest_req[0] = 1'b0;
        if (req[0] && ((last_owner_q != '0) || (rest_req == '0)))
            pick_d = '0;
        else
            pick_d = rr_pick(rr_ptr_q, rest_req);
    end
`else
    always_comb begin
        pick_d = rr_pick(last_owner_q, req);
    end
`endif

    assign busy       = (state_q == S_BURST);
    assign owner_req  = req[owner_q];
    assign owner_last = req_last[owner_q];
    assign accept     = busy && owner_req && !full;
    assign exit_burst = busy && ((accept && ((beat_cnt_q == CNT_MAX) || owner_last)) || !owner_req);

    assign wr_en = accept;
    assign gnt   = gnt_q;
    assign d_in  = busy ? data_arr[owner_q] : '0;

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            beat_cnt_q   <= '0;
            gnt_q        <= '0;
`ifdef ARB_PRI0_EN
            rr_ptr_q     <= LAST_IDX;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        owner_q    <= pick_d;
                        gnt_q      <= NREQ'(1) << pick_d;
                        beat_cnt_q <= '0;
                        state_q    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (accept)
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    if (exit_burst) begin
                        state_q      <= S_IDLE;
                        last_owner_q <= owner_q;
                        gnt_q        <= '0;
`ifdef ARB_PRI0_EN
                        if (owner_q != '0)
                            rr_ptr_q <= owner_q;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
